// File: rtl/gate_truth_checker.sv
// Stimulus-and-check stage for a 2-input gate: sweeps {a,b} = 00..11, waits SETTLE
// cycles per vector, compares y against TRUTH and reports error count and first failure.
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] v_q, v_d;
  logic [3:0] s_q, s_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [1:0] fidx_q, fidx_d;

  logic start_ok_s;
  logic compare_s;
  logic last_s;
  logic mismatch_s;

  assign start_ok_s = start & ~busy_q;
  assign compare_s  = (state_q == ST_RUN) && (s_q == SETTLE_C);
  assign last_s     = compare_s && (v_q == 2'd3);
  assign mismatch_s = (y != TRUTH[v_q]);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= 2'd0;
      s_q     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fv_q    <= 1'b0;
      fidx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fidx_q  <= fidx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep datapath: vector index, settle counter and result bookkeeping
  always_comb begin
    v_d    = v_q;
    s_d    = s_q;
    pass_d = pass_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fidx_d = fidx_q;
    if (start_ok_s) begin
      v_d    = 2'd0;
      s_d    = 4'd0;
      pass_d = 1'b0;
      err_d  = 3'd0;
      fv_d   = 1'b0;
      fidx_d = 2'd0;
    end else if (compare_s) begin
      s_d = 4'd0;
      if (mismatch_s) begin
        err_d = err_q + 3'd1;
        if (!fv_q) begin
          fv_d   = 1'b1;
          fidx_d = v_q;
        end else begin
          fv_d   = fv_q;
          fidx_d = fidx_q;
        end
      end else begin
        err_d = err_q;
      end
      // v stays at 3 after the last vector so {a,b} idles at 11
      if (last_s) begin
        v_d    = v_q;
        pass_d = (err_d == 3'd0);
      end else begin
        v_d    = v_q + 2'd1;
        pass_d = pass_q;
      end
    end else if (state_q == ST_RUN) begin
      s_d = s_q + 4'd1;
    end else begin
      s_d = s_q;
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Outputs come straight from registers
  always_comb begin
    a          = v_q[1];
    b          = v_q[0];
    busy       = busy_q;
    done       = done_q;
    pass       = pass_q;
    err_count  = err_q;
    fail_valid = fv_q;
    fail_idx   = fidx_q;
  end

endmodule
